// File: rtl/bs_readout.sv
// bs_readout: on each bs_ready toggle, reads the 16384-word capture RAM and streams it as framed words.
// Define BS_HEADER_EN to put a tagged header word in front of every frame.
module bs_readout #(
  parameter int unsigned FRAME_LEN = 512,
  parameter logic [7:0]  HDR_TAG   = 8'hB5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bs_ready,
  output logic [13:0] rd_addr,
  input  logic [15:0] rd_data,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sof,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

`ifdef BS_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam int unsigned FL_W     = $clog2(FRAME_LEN);
  localparam logic [13:0] FL_MASK  = 14'(FRAME_LEN - 1);
  localparam logic [13:0] LAST_FRM = 14'((16384 / FRAME_LEN) - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t      state;
  logic        rdy_q;
  logic        pending;
  logic [13:0] word_idx;
  logic [13:0] frame_idx;
  logic [2:0]  capture_seq;

  logic        iss_act;
  logic        hdr_due;
  logic        s1_v;
  logic        s1_hdr;
  logic        s1_sof;
  logic [1:0]  occ;
  logic [15:0] tail_data;
  logic        tail_sof;

  logic        cap_event;
  logic        start;
  logic        pop;
  logic        hdr_push;
  logic        slot_hdr;
  logic        room;
  logic        issue;
  logic [2:0]  fill;
  logic [15:0] hdr_word;
  logic        push;
  logic [15:0] push_word;
  logic        push_sof;

  assign cap_event = bs_ready ^ rdy_q;
  assign start     = (state == IDLE) && (cap_event || pending);
  assign tx_valid  = (occ != 2'd0);
  assign pop       = tx_valid && tx_ready;
  assign hdr_push  = start && HDR_EN;
  assign slot_hdr  = HDR_EN && hdr_due && !start;
  assign hdr_word  = {HDR_TAG, capture_seq, 5'(rd_addr >> FL_W)};

  // A read issued now lands in the skid buffer next clock, so it may only go out
  // if at most one entry will be held once this edge's push and pop have settled.
  assign fill  = {1'b0, occ} + {2'b00, s1_v} + {2'b00, hdr_push} - {2'b00, pop};
  assign room  = (fill <= 3'd1);
  assign issue = (start || iss_act) && room;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    push      = hdr_push || s1_v;
    push_word = rd_data;
    push_sof  = s1_sof;
    if (hdr_push || s1_hdr) begin
      push_word = hdr_word;
      push_sof  = 1'b1;
    end
  end

  // Acceptance-side sequencer: frame bookkeeping, capture queueing and busy.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdy_q       <= bs_ready;
      state       <= IDLE;
      pending     <= 1'b0;
      word_idx    <= '0;
      frame_idx   <= '0;
      capture_seq <= '0;
      overrun_cnt <= '0;
      busy        <= 1'b0;
    end else begin
      rdy_q <= bs_ready;
      if (busy && cap_event) begin
        if (!pending)                  pending     <= 1'b1;
        else if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
      end
      case (state)
        IDLE: if (start) begin
          pending   <= cap_event && pending;
          word_idx  <= '0;
          frame_idx <= '0;
          busy      <= 1'b1;
          if (HDR_EN) state <= HDR;
          else        state <= DATA;
        end
        HDR: if (pop) state <= DATA;
        DATA: if (pop) begin
          if (word_idx == FL_MASK) begin
            word_idx  <= '0;
            frame_idx <= frame_idx + 14'd1;
            if (frame_idx == LAST_FRM) begin
              state       <= IDLE;
              busy        <= 1'b0;
              capture_seq <= capture_seq + 3'd1;
            end else if (HDR_EN) begin
              state <= HDR;
            end
          end else begin
            word_idx <= word_idx + 14'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue side runs ahead of acceptance: header slots and RAM reads share one pipeline stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr <= '0;
      iss_act <= 1'b0;
      hdr_due <= 1'b0;
      s1_v    <= 1'b0;
      s1_hdr  <= 1'b0;
      s1_sof  <= 1'b0;
      occ     <= 2'd0;
      tx_data <= '0;
      tx_sof  <= 1'b0;
    end else begin
      if (start) begin
        iss_act <= 1'b1;
        hdr_due <= 1'b0;
      end
      s1_v   <= issue;
      s1_hdr <= issue && slot_hdr;
      s1_sof <= !HDR_EN && ((rd_addr & FL_MASK) == 14'd0);
      if (issue) begin
        if (slot_hdr) begin
          hdr_due <= 1'b0;
        end else begin
          rd_addr <= rd_addr + 14'd1;
          if ((rd_addr & FL_MASK) == FL_MASK) hdr_due <= HDR_EN;
          if (rd_addr == 14'h3FFF) begin
            iss_act <= 1'b0;
            hdr_due <= 1'b0;
          end
        end
      end
      case (occ)
        2'd0: if (push) begin
          tx_data <= push_word;
          tx_sof  <= push_sof;
          occ     <= 2'd1;
        end
        2'd1: begin
          if (push && pop) begin
            tx_data <= push_word;
            tx_sof  <= push_sof;
          end else if (push) begin
            occ <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        default: if (pop) begin
          tx_data <= tail_data;
          tx_sof  <= tail_sof;
          if (!push) occ <= 2'd1;
        end
      endcase
    end
  end

  // NOTE: the second skid entry is pure payload, only read after being written, so it carries no reset.
  always_ff @(posedge clock) begin
    if (push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop))) begin
      tail_data <= push_word;
      tail_sof  <= push_sof;
    end
  end

endmodule

// File: tb/tb_bs_readout.sv
// Bench for bs_readout: random backpressure and toggle timing against a queue model of the framed stream.
// Honours BS_HEADER_EN the same way the design does.
module tb_bs_readout;

`ifdef BS_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int CAP_LEN = 16384 + (HDR_EN ? 32 : 0);

  logic        clock = 1'b0;
  logic        reset;
  logic        bs_ready;
  logic [13:0] rd_addr;
  logic [15:0] rd_data;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sof;
  logic        busy;
  logic [7:0]  overrun_cnt;

  bs_readout #(.FRAME_LEN(512), .HDR_TAG(8'hB5)) dut (
    .clock(clock), .reset(reset), .bs_ready(bs_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sof(tx_sof),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clock = ~clock;

  // Capture RAM holding its own address as data, one clock of read latency.
  always @(posedge clock) rd_data <= {2'b00, rd_addr};

  int          n_vec = 0;
  int          n_miss = 0;
  logic [16:0] exp_q[$];
  int          word_err = 0;
  int          stall_err = 0;
  int          n_acc = 0;
  int          cyc = 0;
  int          c_first = -1;
  int          c_last = -1;
  bit          rand_ready = 1'b0;
  bit          stalled_prev = 1'b0;
  logic [16:0] prev_word = '0;
  logic [16:0] first_word = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One capture as the host should see it: optional header, then 512 ascending addresses per frame.
  task automatic push_capture(input logic [2:0] seq);
    for (int f = 0; f < 32; f++) begin
      if (HDR_EN) exp_q.push_back({1'b1, 8'hB5, seq, 5'(f)});
      for (int w = 0; w < 512; w++) exp_q.push_back({(!HDR_EN && w == 0), 16'(f * 512 + w)});
    end
  endtask

  // Advance to the next falling edge, choose tx_ready for the coming rising edge, score any acceptance.
  task automatic step();
    logic [16:0] e;
    logic [16:0] cur;
    @(negedge clock);
    tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    cur = {tx_sof, tx_data};
    if (stalled_prev && (!tx_valid || cur !== prev_word)) stall_err++;
    stalled_prev = tx_valid && !tx_ready;
    prev_word    = cur;
    if (tx_valid && tx_ready) begin
      n_acc++;
      if (n_acc == 1) begin
        c_first    = cyc;
        first_word = cur;
      end
      if (n_acc == CAP_LEN) c_last = cyc;
      if (exp_q.size() == 0) word_err++;
      else begin
        e = exp_q.pop_front();
        if (e !== cur) word_err++;
      end
    end
    cyc++;
  endtask

  int t1;
  int t2;
  int base;

  initial begin
    reset    = 1'b1;
    bs_ready = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_sof", tx_sof, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_overrun", overrun_cnt, 0);
    reset = 1'b0;
    repeat (3) step();
    check("idle_busy", busy, 0);

    // First capture, ready high, with two further toggles landing mid-readout.
    n_acc = 0;
    push_capture(3'd0);
    bs_ready = ~bs_ready;
    @(posedge clock);
    #1;
    check("lat_busy_e1", busy, 1);
    check("lat_valid_e1", tx_valid, HDR_EN);
    step();
    step();
    check("lat_valid_e2", tx_valid, 1);

    t1 = $urandom_range(50, 3000);
    t2 = t1 + $urandom_range(1, 3000);
    for (int g = 0; g < 20000 && n_acc < t1; g++) step();
    bs_ready = ~bs_ready;
    push_capture(3'd1);
    for (int g = 0; g < 20000 && n_acc < t2; g++) step();
    bs_ready = ~bs_ready;
    for (int g = 0; g < 20000 && n_acc < CAP_LEN; g++) step();
    check("span_cap1", c_last - c_first + 1, CAP_LEN);
    step();
    check("busy_fall_cap1", busy, 0);
    step();
    check("pending_start", busy, 1);
    check("overrun_one", overrun_cnt, 1);

    // Toggle on the same clock as the final acceptance of the second capture.
    for (int g = 0; g < 20000 && exp_q.size() != 0; g++) step();
    check("cap2_drained", exp_q.size(), 0);
    bs_ready = ~bs_ready;
    push_capture(3'd2);
    step();
    check("busy_fall_cap2", busy, 0);
    step();
    check("boundary_start", busy, 1);
    check("boundary_overrun", overrun_cnt, 1);

    // Third capture under 30 % ready, then a reset in the middle of it.
    rand_ready = 1'b1;
    base = n_acc;
    for (int g = 0; g < 20000 && (n_acc - base) < 700; g++) step();
    check("bp_words_seen", n_acc - base, 700);
    check("bp_stream", word_err, 0);
    check("bp_stall_stable", stall_err, 0);
    reset    = 1'b1;
    tx_ready = 1'b0;
    @(negedge clock);
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_addr", rd_addr, 0);
    bs_ready = ~bs_ready;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    stalled_prev = 1'b0;
    rand_ready   = 1'b0;
    repeat (4) step();
    check("no_event_after_rst", busy, 0);
    check("rst_overrun_clear", overrun_cnt, 0);

    // Clean restart after the abort.
    n_acc = 0;
    push_capture(3'd0);
    bs_ready = ~bs_ready;
    for (int g = 0; g < 20000 && exp_q.size() != 0; g++) step();
    check("restart_drained", exp_q.size(), 0);
    check("restart_first", first_word, HDR_EN ? 17'h1B500 : 17'h10000);
    check("restart_count", n_acc, CAP_LEN);
    step();
    check("restart_busy_fall", busy, 0);
    check("restart_overrun", overrun_cnt, 0);
    check("stream_words", word_err, 0);
    check("stall_stable", stall_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
